// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding,
// frame geometry, common keyboard commands and frame-building helpers.
package ps2_pkg;

    // State encoding for the host-to-device transmit sequence.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_START     = 3'd3;
    localparam logic [2:0] ST_DATA      = 3'd4;
    localparam logic [2:0] ST_ACK       = 3'd5;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_INHIBIT   = ST_INHIBIT,
        S_REQ       = ST_REQ,
        S_START     = ST_START,
        S_DATA      = ST_DATA,
        S_ACK       = ST_ACK,
        S_WAIT_IDLE = ST_WAIT_IDLE
    } ps2_state_t;

    // Data bits 0..7, parity, stop.
    localparam int         PS2_FRAME_BITS = 10;
    localparam logic [3:0] PS2_LAST_BIT   = 4'd9;

    // Common keyboard commands.
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Serial order is LSB first: data[0] at index 0, stop bit at the top.
    function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one asynchronous PS/2 pin into the clock domain (2-FF synchronizer),
// debounces it so the level only changes after FILTER_LEN consecutive equal
// samples, and optionally reports high-to-low transitions of the filtered
// level as a one-cycle pulse.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter bit EN_FALL    = 1'b1
) (
    input  logic clk,
    input  logic res,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_r;
    logic             level_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize the pin and let the filtered level follow only a stable run
    // of FILTER_LEN differing samples; idle bus level is high.
    always_ff @(posedge clk) begin
        if (res) begin
            sync_r  <= 2'b11;
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            fall_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], pin};
            if (sync_r[1] == level_r) begin
                cnt_r  <= {CNT_W{1'b0}};
                fall_r <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync_r[1];
                cnt_r   <= {CNT_W{1'b0}};
                fall_r  <= EN_FALL & level_r;
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1);
                fall_r <= 1'b0;
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request to
// send, shifts out start/data/parity/stop on device clock falls, checks the
// device ACK and gives up with an error if the device stops clocking.
// Both PS/2 lines are driven as open-drain pull-downs.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2600,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int              INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    // Filtered line levels and the device clock fall event.
    logic clk_level_s;
    logic clk_fall_s;
    logic data_level_s;
    logic data_fall_unused;

    // Registered state and outputs, with their next-state values.
    ps2_state_t                state_r, state_s;
    logic [PS2_FRAME_BITS-1:0] frame_r, frame_s;
    logic [3:0]                bit_cnt_r, bit_cnt_s;
    logic [INH_W-1:0]          inh_cnt_r, inh_cnt_s;
    logic [TO_W-1:0]           to_cnt_r, to_cnt_s;
    logic                      tx_ready_r, tx_ready_s;
    logic                      busy_r, busy_s;
    logic                      done_r, done_s;
    logic                      error_r, error_s;
    logic                      clk_drv_r, clk_drv_s;
    logic                      data_drv_r, data_drv_s;
    logic                      to_active_s;
    logic                      to_hit_s;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN),
        .EN_FALL    (1'b1)
    ) u_clk_filter (
        .clk   (clk),
        .res   (res),
        .pin   (ps2_clk_in),
        .level (clk_level_s),
        .fall  (clk_fall_s)
    );

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN),
        .EN_FALL    (1'b0)
    ) u_data_filter (
        .clk   (clk),
        .res   (res),
        .pin   (ps2_data_in),
        .level (data_level_s),
        .fall  (data_fall_unused)
    );

    // Timeout watch: only armed while waiting on the device; a fall in the
    // same cycle restarts the window instead of expiring it.
    always_comb begin
        to_active_s = (state_r == S_START) || (state_r == S_DATA) ||
                      (state_r == S_ACK)   || (state_r == S_WAIT_IDLE);
        if (to_active_s && !clk_fall_s && (to_cnt_r == TO_LAST)) begin
            to_hit_s = 1'b1;
        end else begin
            to_hit_s = 1'b0;
        end
    end

    // Next-state and next-output logic of the transmit sequence.
    always_comb begin
        state_s    = state_r;
        frame_s    = frame_r;
        bit_cnt_s  = bit_cnt_r;
        inh_cnt_s  = inh_cnt_r;
        clk_drv_s  = clk_drv_r;
        data_drv_s = data_drv_r;
        done_s     = 1'b0;
        error_s    = 1'b0;

        case (state_r)
            S_IDLE: begin
                clk_drv_s  = 1'b0;
                data_drv_s = 1'b0;
                if (tx_valid && tx_ready_r) begin
                    frame_s   = build_frame(tx_data);
                    inh_cnt_s = {INH_W{1'b0}};
                    bit_cnt_s = 4'd0;
                    clk_drv_s = 1'b1;
                    state_s   = S_INHIBIT;
                end else begin
                    state_s = S_IDLE;
                end
            end

            // Hold the clock low long enough for the device to abort any
            // transmission of its own; device activity is ignored here.
            S_INHIBIT: begin
                clk_drv_s = 1'b1;
                if (inh_cnt_r == INH_LAST) begin
                    data_drv_s = 1'b1;
                    state_s    = S_REQ;
                end else begin
                    inh_cnt_s = inh_cnt_r + INH_W'(1);
                end
            end

            // One cycle with both lines low, then release clock with data
            // still low: that is the request-to-send / start bit.
            S_REQ: begin
                clk_drv_s  = 1'b0;
                data_drv_s = 1'b1;
                state_s    = S_START;
            end

            S_START: begin
                if (to_hit_s) begin
                    clk_drv_s  = 1'b0;
                    data_drv_s = 1'b0;
                    error_s    = 1'b1;
                    state_s    = S_IDLE;
                end else if (clk_fall_s) begin
                    data_drv_s = ~frame_r[0];
                    bit_cnt_s  = 4'd1;
                    state_s    = S_DATA;
                end else begin
                    state_s = S_START;
                end
            end

            // Each device fall presents the next frame bit; the fall that
            // presents the stop bit (released line) ends the data phase.
            S_DATA: begin
                if (to_hit_s) begin
                    clk_drv_s  = 1'b0;
                    data_drv_s = 1'b0;
                    error_s    = 1'b1;
                    state_s    = S_IDLE;
                end else if (clk_fall_s) begin
                    data_drv_s = ~frame_r[bit_cnt_r];
                    if (bit_cnt_r == PS2_LAST_BIT) begin
                        bit_cnt_s = 4'd0;
                        state_s   = S_ACK;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end

            // The device pulls data low during its next clock low as ACK.
            S_ACK: begin
                data_drv_s = 1'b0;
                if (to_hit_s) begin
                    clk_drv_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = S_IDLE;
                end else if (clk_fall_s) begin
                    if (data_level_s) begin
                        error_s = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_WAIT_IDLE;
                    end
                end else begin
                    state_s = S_ACK;
                end
            end

            // Completion is reported only once the device has let go of both
            // lines, so the next frame never collides with the ACK tail.
            S_WAIT_IDLE: begin
                if (to_hit_s) begin
                    clk_drv_s  = 1'b0;
                    data_drv_s = 1'b0;
                    error_s    = 1'b1;
                    state_s    = S_IDLE;
                end else if (clk_level_s && data_level_s) begin
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT_IDLE;
                end
            end

            default: begin
                clk_drv_s  = 1'b0;
                data_drv_s = 1'b0;
                bit_cnt_s  = 4'd0;
                state_s    = S_IDLE;
            end
        endcase

        if ((state_s != state_r) || clk_fall_s || !to_active_s) begin
            to_cnt_s = {TO_W{1'b0}};
        end else begin
            to_cnt_s = to_cnt_r + TO_W'(1);
        end

        // Ready only after a full cycle in IDLE, giving one idle cycle
        // between the done/error pulse and the next accept.
        tx_ready_s = (state_r == S_IDLE) && (state_s == S_IDLE);
        busy_s     = (state_s != S_IDLE);
    end

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r    <= S_IDLE;
            frame_r    <= {PS2_FRAME_BITS{1'b0}};
            bit_cnt_r  <= 4'd0;
            inh_cnt_r  <= {INH_W{1'b0}};
            to_cnt_r   <= {TO_W{1'b0}};
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            clk_drv_r  <= 1'b0;
            data_drv_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            frame_r    <= frame_s;
            bit_cnt_r  <= bit_cnt_s;
            inh_cnt_r  <= inh_cnt_s;
            to_cnt_r   <= to_cnt_s;
            tx_ready_r <= tx_ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
            clk_drv_r  <= clk_drv_s;
            data_drv_r <= data_drv_s;
        end
    end

    assign tx_ready           = tx_ready_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign error              = error_r;
    assign ps2_clk_drive_low  = clk_drv_r;
    assign ps2_data_drive_low = data_drv_r;

endmodule
